wptr_full_level: RTL and testbench

//  Write-domain pointer and flag generator for the dual-clock async FIFO. Parametrised successor of the

---
 rtl/async_fifo_pkg.sv | 22 ++
 rtl/wptr_full_level_gray2bin.sv | 14 +
 rtl/wptr_full_level.sv | 99 +++++++++
 tb/tb_wptr_full_level.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared helpers for the dual-clock FIFO pointer blocks (write and read side).
// Gray/binary conversions operate on 32-bit containers; callers size the result.
package async_fifo_pkg;

    localparam int FIFO_ASIZE = 4;
    localparam int FIFO_DEPTH = 1 << FIFO_ASIZE;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down, built by doubling shifts.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] r;
        r = g;
        for (int s = 1; s < 32; s = s << 1) begin
            r = r ^ (r >> s);
        end
        return r;
    endfunction

endpackage

// File: rtl/wptr_full_level_gray2bin.sv
// Combinational Gray-to-binary converter; shared by the write and read pointer blocks.
module gray2bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign o_bin[i] = ^i_gray[W-1:i];
    end

endmodule

// File: rtl/wptr_full_level.sv
// Write-domain pointer, full/almost-full flags, fill level and sticky overflow
// for the dual-clock FIFO. Consumes the synchronised Gray read pointer.
module wptr_full_level
    import async_fifo_pkg::*;
#(
    parameter int ASIZE     = FIFO_ASIZE,
    parameter int AFULL_RST = 12
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic             winc,
    input  logic [ASIZE:0]   wq2_rptr,
    input  logic [ASIZE:0]   wafull_lvl,
    input  logic             wafull_ld,
    input  logic             wovf_clr,
    output logic             wen,
    output logic [ASIZE-1:0] waddr,
    output logic [ASIZE:0]   wptr,
    output logic             wfull,
    output logic             walmost_full,
    output logic [ASIZE:0]   wlevel,
    output logic             woverflow
);

    logic [ASIZE:0] r_bin;
    logic [ASIZE:0] r_wptr;
    logic           r_full;
    logic           r_afull;
    logic [ASIZE:0] r_level;
    logic           r_ovf;
    logic [ASIZE:0] r_thr;

    logic           w_wen;
    logic [ASIZE:0] w_binnext;
    logic [ASIZE:0] w_gnext;
    logic [ASIZE:0] w_rbin;
    logic [ASIZE:0] w_lvl_next;
    logic [ASIZE:0] w_full_ptr;
    logic           w_full_next;
    logic           w_afull_next;

    gray2bin #(.W(ASIZE + 1)) u_rptr_g2b (
        .i_gray (wq2_rptr),
        .o_bin  (w_rbin)
    );

    assign w_wen      = winc & ~r_full;
    assign w_binnext  = r_bin + (ASIZE + 1)'(w_wen);
    assign w_gnext    = (ASIZE + 1)'(bin2gray(32'(w_binnext)));
    // Modulo difference; the extra MSB keeps a full FIFO distinct from an empty one.
    assign w_lvl_next = w_binnext - w_rbin;

    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    assign w_full_ptr   = {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]};
    assign w_full_next  = (w_gnext == w_full_ptr);
    assign w_afull_next = (w_lvl_next >= r_thr);

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_bin   <= '0;
            r_wptr  <= '0;
            r_full  <= 1'b0;
            r_afull <= 1'b0;
            r_level <= '0;
        end else begin
            r_bin   <= w_binnext;
            r_wptr  <= w_gnext;
            r_full  <= w_full_next;
            r_afull <= w_afull_next;
            r_level <= w_lvl_next;
        end
    end

    // Overflow set wins over a same-cycle clear; threshold applies from the next compare.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_ovf <= 1'b0;
            r_thr <= (ASIZE + 1)'(AFULL_RST);
        end else begin
            if (winc && r_full) begin
                r_ovf <= 1'b1;
            end else if (wovf_clr) begin
                r_ovf <= 1'b0;
            end
            if (wafull_ld) begin
                r_thr <= wafull_lvl;
            end
        end
    end

    assign wen          = w_wen;
    assign waddr        = r_bin[ASIZE-1:0];
    assign wptr         = r_wptr;
    assign wfull        = r_full;
    assign walmost_full = r_afull;
    assign wlevel       = r_level;
    assign woverflow    = r_ovf;

endmodule

// File: tb/tb_wptr_full_level.sv
// Scoreboard bench for wptr_full_level (ASIZE=4): counts of accepted writes and
// read-pointer advances form the reference; a monitor compares registered outputs.
module tb_wptr_full_level;

    localparam int ASIZE = 4;
    localparam int DEPTH = 16;

    logic             wclk = 1'b0;
    logic             wrst = 1'b1;
    logic             winc = 1'b0;
    logic [ASIZE:0]   wq2_rptr = '0;
    logic [ASIZE:0]   wafull_lvl = '0;
    logic             wafull_ld = 1'b0;
    logic             wovf_clr = 1'b0;
    logic             wen;
    logic [ASIZE-1:0] waddr;
    logic [ASIZE:0]   wptr;
    logic             wfull;
    logic             walmost_full;
    logic [ASIZE:0]   wlevel;
    logic             woverflow;

    wptr_full_level #(.ASIZE(ASIZE), .AFULL_RST(12)) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .winc         (winc),
        .wq2_rptr     (wq2_rptr),
        .wafull_lvl   (wafull_lvl),
        .wafull_ld    (wafull_ld),
        .wovf_clr     (wovf_clr),
        .wen          (wen),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .woverflow    (woverflow)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        int wptr;
        int wlevel;
        int wfull;
        int afull;
        int ovf;
        int waddr;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference state: totals of accepted writes and read advances, plus registered flags.
    int m_writes = 0;
    int m_reads  = 0;
    int m_full   = 0;
    int m_ovf    = 0;
    int m_thr    = 12;

    function automatic int gray(input int v);
        int b;
        b = v % 32;
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit inc, input int rd, input bit ld, input int lvl, input bit clr);
        exp_t e;
        int   acc;
        int   level;
        @(negedge wclk);
        winc       = inc;
        m_reads    = rd;
        wq2_rptr   = 5'(gray(rd));
        wafull_ld  = ld;
        wafull_lvl = 5'(lvl);
        wovf_clr   = clr;
        #1;
        acc = (inc && (m_full == 0)) ? 1 : 0;
        chk("wen", int'(wen), acc);
        chk("waddr", int'(waddr), m_writes % DEPTH);
        m_writes = m_writes + acc;
        if (inc && m_full != 0) m_ovf = 1;
        else if (clr) m_ovf = 0;
        level    = m_writes - m_reads;
        m_full   = (level == DEPTH) ? 1 : 0;
        e.wptr   = gray(m_writes);
        e.wlevel = level;
        e.wfull  = m_full;
        e.afull  = (level >= m_thr) ? 1 : 0;
        e.ovf    = m_ovf;
        e.waddr  = m_writes % DEPTH;
        if (ld) m_thr = lvl;
        q.push_back(e);
    endtask

    task automatic idle_step();
        step(1'b0, m_reads, 1'b0, 0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge wclk);
        #3;
        wrst = 1'b1;
        #1;
        chk("rst_wptr", int'(wptr), 0);
        chk("rst_wfull", int'(wfull), 0);
        chk("rst_afull", int'(walmost_full), 0);
        chk("rst_wlevel", int'(wlevel), 0);
        chk("rst_ovf", int'(woverflow), 0);
        chk("rst_waddr", int'(waddr), 0);
        winc = 1'b0; wq2_rptr = '0; wafull_ld = 1'b0; wovf_clr = 1'b0;
        m_writes = 0; m_reads = 0; m_full = 0; m_ovf = 0; m_thr = 12;
        repeat (2) @(negedge wclk);
        wrst = 1'b0;
    endtask

    // Monitor: registered outputs settle just after each rising edge.
    always @(posedge wclk) begin
        exp_t e;
        #1;
        if (!wrst && q.size() > 0) begin
            e = q.pop_front();
            chk("wptr", int'(wptr), e.wptr);
            chk("wlevel", int'(wlevel), e.wlevel);
            chk("wfull", int'(wfull), e.wfull);
            chk("walmost_full", int'(walmost_full), e.afull);
            chk("woverflow", int'(woverflow), e.ovf);
            chk("waddr_reg", int'(waddr), e.waddr);
            chk("wfull_vs_level", int'(wfull), (wlevel == 5'(DEPTH)) ? 1 : 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cnt;
        int rd;
        repeat (3) @(negedge wclk);
        wrst = 1'b0;

        // Reset asserted mid-burst with flags raised.
        for (int i = 0; i < 13; i++) step(1'b1, 0, 1'b0, 0, 1'b0);
        step(1'b1, 0, 1'b0, 0, 1'b0);
        do_reset();

        // Fill from empty: threshold back at its reset value.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 0, 1'b0, 0, 1'b0);
        @(posedge wclk); #2;
        chk("fill_wptr_const", int'(wptr), 5'b11000);

        // Overflow while full, clear with a write, then clear alone.
        step(1'b1, 0, 1'b0, 0, 1'b0);
        step(1'b1, 0, 1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0, 0, 1'b1);

        // Drain two words via Gray read pointer 1 then 3.
        step(1'b0, 1, 1'b0, 0, 1'b0);
        step(1'b0, 2, 1'b0, 0, 1'b0);
        idle_step();

        // 40 more words with interleaved reads; pointers wrap.
        acc_cnt = 0;
        for (int i = 0; i < 200 && acc_cnt < 40; i++) begin
            rd = (i % 2 == 1 && m_reads < m_writes) ? m_reads + 1 : m_reads;
            if (m_full == 0) acc_cnt++;
            step(1'b1, rd, 1'b0, 0, 1'b0);
        end
        chk("wrap_accepted", acc_cnt, 40);
        idle_step();

        // Threshold: zero asserts at level 0, above DEPTH never asserts.
        do_reset();
        step(1'b0, 0, 1'b1, 0, 1'b0);
        idle_step();
        idle_step();
        step(1'b0, 0, 1'b1, 17, 1'b0);
        for (int i = 0; i < DEPTH + 2; i++) step(1'b1, 0, 1'b0, 0, 1'b0);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rd = m_reads;
            if (m_reads < m_writes && $urandom_range(0, 2) == 0) rd = m_reads + 1;
            step(1'b1 & ($urandom_range(0, 3) != 0), rd,
                 ($urandom_range(0, 30) == 0), $urandom_range(0, 17),
                 ($urandom_range(0, 9) == 0));
        end

        @(posedge wclk); #3;
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
